// File: rtl/alu_ex_stage.sv
// Execute-stage front end: decodes ALUOp/funct, drives the external ALU, and registers its response into EX/MEM.
// Output latency is 1 cycle. in_ready falls only while an entry is held and MEM is not accepting it.
module alu_ex_stage #(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [5:0]       in_funct,
  input  logic [W-1:0]     in_rs_data,
  input  logic [W-1:0]     in_rt_data,
  input  logic [W-1:0]     in_imm,
  input  logic             in_alu_src,
  input  logic [4:0]       in_wreg,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_branch,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_control,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic [W-1:0]     out_store_data,
  output logic [4:0]       out_wreg,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch_taken,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic illegal;
  logic xfer;

  always_comb begin
    alu_control = CTL_ADD;
    illegal     = 1'b0;
    unique case (in_alu_op)
      2'b00: alu_control = CTL_ADD;
      2'b01: alu_control = CTL_SUB;
      2'b11: alu_control = CTL_OR;
      2'b10: begin
        case (in_funct)
          6'b100000: alu_control = CTL_ADD;
          6'b100010: alu_control = CTL_SUB;
          6'b100100: alu_control = CTL_AND;
          6'b100101: alu_control = CTL_OR;
          6'b101010: alu_control = CTL_SLT;
          // Unknown R-type funct still issues as ADD so the pipe never stalls on it.
          default: begin
            alu_control = CTL_ADD;
            illegal     = 1'b1;
          end
        endcase
      end
      default: alu_control = CTL_ADD;
    endcase
  end

  assign alu_a = in_rs_data;
  assign alu_b = in_alu_src ? in_imm : in_rt_data;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_zero         <= 1'b0;
      out_store_data   <= '0;
      out_wreg         <= '0;
      out_reg_write    <= 1'b0;
      out_mem_read     <= 1'b0;
      out_mem_write    <= 1'b0;
      out_branch_taken <= 1'b0;
    end else if (xfer) begin
      out_valid        <= 1'b1;
      out_result       <= alu_result;
      out_zero         <= alu_zero;
      out_store_data   <= in_rt_data;
      out_wreg         <= in_wreg;
      out_reg_write    <= in_reg_write;
      out_mem_read     <= in_mem_read;
      out_mem_write    <= in_mem_write;
      out_branch_taken <= in_branch && alu_zero;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (xfer && illegal && illegal_cnt != CNT_MAX) begin
      illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed-vector bench for alu_ex_stage with a behavioural ALU on the alu_* ports.
module tb_alu_ex_stage;
  localparam int W     = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alu_op;
  logic [5:0]       in_funct;
  logic [W-1:0]     in_rs_data;
  logic [W-1:0]     in_rt_data;
  logic [W-1:0]     in_imm;
  logic             in_alu_src;
  logic [4:0]       in_wreg;
  logic             in_reg_write;
  logic             in_mem_read;
  logic             in_mem_write;
  logic             in_branch;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [2:0]       alu_control;
  logic [W-1:0]     alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic             out_zero;
  logic [W-1:0]     out_store_data;
  logic [4:0]       out_wreg;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic             out_branch_taken;
  logic [CNT_W-1:0] illegal_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ex_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct(in_funct),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_wreg(in_wreg),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_branch(in_branch),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_store_data(out_store_data), .out_wreg(out_wreg),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch_taken(out_branch_taken),
    .illegal_cnt(illegal_cnt)
  );

  // Reference ALU
  always_comb begin
    alu_result = '0;
    case (alu_control)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a + alu_b;
      3'b110: alu_result = alu_a - alu_b;
      3'b111: alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] rs,
                       input logic [W-1:0] rt, input logic [W-1:0] imm, input logic src,
                       input logic [4:0] wr, input logic br);
    in_valid   = 1'b1;
    in_alu_op  = op;
    in_funct   = fn;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm     = imm;
    in_alu_src = src;
    in_wreg    = wr;
    in_branch  = br;
    #1;
  endtask

  logic [5:0]   sw_fn  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0]   sw_ctl [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
  logic [W-1:0] sw_res [4] = '{32'd3, 32'd2, 32'd15, 32'd0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_alu_op = 2'b00; in_funct = '0; in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    in_alu_src = 1'b0; in_wreg = '0; in_reg_write = 1'b0; in_mem_read = 1'b0;
    in_mem_write = 1'b0; in_branch = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // R-type add
    in_reg_write = 1'b1;
    drive(2'b10, 6'b100000, 32'd10, 32'd7, 32'd99, 1'b0, 5'd3, 1'b0);
    chk("add_ctl", alu_control, 3'b010);
    chk("add_alu_b", alu_b, 32'd7);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 32'd17);
    chk("add_zero", out_zero, 0);
    chk("add_wreg", out_wreg, 5'd3);
    chk("add_store", out_store_data, 32'd7);

    // Back-to-back sweep, no bubbles
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, sw_fn[i], 32'b1010, 32'b0111, 32'd0, 1'b0, 5'(i + 8), 1'b0);
      chk("sweep_ctl", alu_control, sw_ctl[i]);
      chk("sweep_rdy", in_ready, 1);
      step();
      chk("sweep_valid", out_valid, 1);
      chk("sweep_result", out_result, sw_res[i]);
    end
    chk("sweep_no_illegal", illegal_cnt, 0);

    // beq taken / not taken
    in_reg_write = 1'b0;
    drive(2'b01, 6'b000000, 32'd5, 32'd5, 32'd0, 1'b0, 5'd0, 1'b1);
    chk("beq_ctl", alu_control, 3'b110);
    step();
    chk("beq_result", out_result, 0);
    chk("beq_zero", out_zero, 1);
    chk("beq_taken", out_branch_taken, 1);
    drive(2'b01, 6'b000000, 32'd5, 32'd6, 32'd0, 1'b0, 5'd0, 1'b1);
    step();
    chk("bne_result", out_result, 32'hFFFF_FFFF);
    chk("bne_zero", out_zero, 0);
    chk("bne_taken", out_branch_taken, 0);

    // ori
    drive(2'b11, 6'b000000, 32'h00F0, 32'd0, 32'h000F, 1'b1, 5'd4, 1'b0);
    chk("ori_ctl", alu_control, 3'b001);
    step();
    chk("ori_result", out_result, 32'h00FF);

    // Back-pressure
    in_reg_write = 1'b1; in_mem_read = 1'b1;
    drive(2'b00, 6'b000000, 32'd100, 32'd55, 32'd8, 1'b1, 5'd9, 1'b0);
    chk("lw_alu_b", alu_b, 32'd8);
    step();
    chk("lw_result", out_result, 32'd108);
    chk("lw_mem_read", out_mem_read, 1);
    out_ready = 1'b0;
    in_mem_read = 1'b0;
    drive(2'b00, 6'b000000, 32'd200, 32'd0, 32'd4, 1'b1, 5'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_result", out_result, 32'd108);
      chk("stall_wreg", out_wreg, 5'd9);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    step();
    chk("second_valid", out_valid, 1);
    chk("second_result", out_result, 32'd204);
    chk("second_mem_read", out_mem_read, 0);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold", out_result, 32'd204);
    step();
    chk("no_dup_valid", out_valid, 0);

    // Illegal funct, with an idle gap that must not count
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 6'b000111, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 1'b0);
      chk("ill_ctl", alu_control, 3'b010);
      step();
      chk("ill_result", out_result, 32'd3);
    end
    chk("ill_cnt5", illegal_cnt, 5);
    in_valid = 1'b0;
    step(); step();
    chk("ill_idle_cnt", illegal_cnt, 5);
    for (int i = 5; i < 300; i++) begin
      drive(2'b10, 6'b000111, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 1'b0);
      chk("ill_ctl", alu_control, 3'b010);
      step();
      if (i == 253) chk("ill_cnt254", illegal_cnt, 254);
    end
    chk("ill_sat", illegal_cnt, 255);

    // Reset while stalled
    drive(2'b10, 6'b100000, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2, 1'b0);
    step();
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_cnt", illegal_cnt, 0);
    chk("rst2_result", out_result, 0);
    chk("rst2_reg_write", out_reg_write, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
Execute-stage front end of the MIPS pipeline. It is the driving end of the ALU interface (a, b, control -> result, zero).
- Accepts one ID/EX bundle per handshake.
- Decodes ALUOp/funct into the 3-bit ALU control code and selects the ALU operands.
- Captures the combinational ALU result and zero flag into an EX/MEM pipeline register with valid/ready back-pressure.
- Sits between the ID/EX register and the MEM stage; the ALU instance is external and wired to the alu_* ports.

Parameters:
W, 32, datapath width (a, b, result, immediate)
CNT_W, 8, width of the saturating illegal-funct counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ID/EX bundle valid
in_ready  out  1  stage can accept bundle this cycle
in_alu_op  in  2  00 mem, 01 branch, 10 R-type, 11 ori
in_funct  in  6  instruction funct field
in_rs_data  in  W  register rs value
in_rt_data  in  W  register rt value
in_imm  in  W  extended immediate
in_alu_src  in  1  1: b = imm, 0: b = rt
in_wreg  in  5  destination register
in_reg_write, in_mem_read, in_mem_write, in_branch  in  1 each  control bits passed through
alu_a  out  W  to ALU a
alu_b  out  W  to ALU b
alu_control  out  3  to ALU control
alu_result  in  W  from ALU result
alu_zero  in  1  from ALU zero
out_valid  out  1  EX/MEM entry valid
out_ready  in  1  MEM stage accepts entry
out_result  out  W  registered ALU result
out_zero  out  1  registered zero
out_store_data  out  W  registered rt value
out_wreg  out  5  registered destination
out_reg_write, out_mem_read, out_mem_write  out  1 each  registered control bits
out_branch_taken  out  1  registered in_branch & alu_zero
illegal_cnt  out  CNT_W  saturating count of accepted illegal R-type funct codes

Behaviour:
- Control encoding (fixed): 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. Codes 011 and 100 are never driven.
- Decode (combinational, from in_* fields):
  - ALUOp 00 -> 010
  - ALUOp 01 -> 110
  - ALUOp 11 -> 001
  - ALUOp 10 -> funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111
  - Any other funct with ALUOp 10 -> 010 and illegal=1
- Operand select: alu_a = in_rs_data; alu_b = in_alu_src ? in_imm : in_rt_data.
- alu_* are driven every cycle regardless of in_valid. No registering on the ALU side.
- Handshake:
  - Transfer occurs when in_valid & in_ready.
  - in_ready = !out_valid | out_ready (combinational pass-through of out_ready).
- Latency: exactly 1 cycle. A bundle accepted at edge N appears on out_* after edge N with out_valid=1.
- Output register behaviour:
  - On transfer: load all out_* from the current ALU response and in_* fields; out_valid <= 1.
  - On out_ready & out_valid with no new transfer: out_valid <= 0. Data fields hold their last value.
  - While out_valid & !out_ready: all out_* hold stable, in_ready=0, no ALU capture.
  - Simultaneous drain and accept (out_valid & out_ready & in_valid): new bundle loaded, out_valid stays 1. Full throughput, one bundle per cycle.
- out_branch_taken = in_branch & alu_zero, captured at transfer.
- illegal_cnt increments by 1 on each transfer with illegal=1 and saturates at 2^CNT_W-1. Non-transferred illegal bundles (in_valid=0 or stalled) are not counted.
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_result=0, out_zero=0, out_store_data=0, out_wreg=0, all out control bits=0, out_branch_taken=0, illegal_cnt=0.
  - Reset mid-stall discards the held entry.
  - in_ready is 1 during and after reset (derived from out_valid=0).
- Arithmetic is performed by the ALU. This block adds no width extension or truncation; all data paths are W bits.

Test Plan:
(The bench instantiates the team's ALU on the alu_* ports.)
- R-type add: rs=10, rt=7, funct=100000, alu_src=0, out_ready=1 -> alu_control=010; next cycle out_valid=1, out_result=17, out_zero=0.
- R-type sweep: rs=0b1010, rt=0b0111, one bundle per cycle for funct sub/and/or/slt -> out_result 3, 2, 15, 0 on consecutive cycles with no bubbles.
- beq: ALUOp=01, rs=rt=5, in_branch=1 -> alu_control=110, out_result=0, out_zero=1, out_branch_taken=1. Same with rt=6 -> out_branch_taken=0.
- Back-pressure: accept lw (ALUOp 00, rs=100, imm=8, alu_src=1), then hold out_ready=0 for 3 cycles with a second bundle valid -> in_ready=0, out_result stays 108. Release -> second bundle appears next cycle; no loss or duplication.
- Illegal funct: 300 accepted bundles with funct=000111 -> alu_control=010 each; illegal_cnt saturates at 255.
- Reset while stalled with out_valid=1 -> next cycle out_valid=0, illegal_cnt=0, in_ready=1.
